// File: rtl/multi_project_io_arbiter_if.sv
// Bus bundle between the management/user-area side and the IO arbiter.
// The slave side is the arbiter. The master side is whoever drives the
// selection and the per-project pad data.
interface multi_project_io_arbiter_if #(
    parameter int NUM_PROJ = 4,
    parameter int IO_W     = 38,
    parameter int SEL_W    = 5
);
    logic [SEL_W-1:0]         sel_i;
    logic                     sel_stb_i;
    logic [NUM_PROJ*IO_W-1:0] proj_io_out_i;
    logic [NUM_PROJ*IO_W-1:0] proj_io_oeb_i;
    logic [IO_W-1:0]          io_out;
    logic [IO_W-1:0]          io_oeb;
    logic [NUM_PROJ-1:0]      proj_rst_o;
    logic [NUM_PROJ-1:0]      proj_active_o;
    logic [SEL_W-1:0]         cur_sel_o;
    logic                     busy_o;

    modport master (
        output sel_i, sel_stb_i, proj_io_out_i, proj_io_oeb_i,
        input  io_out, io_oeb, proj_rst_o, proj_active_o, cur_sel_o, busy_o
    );

    modport slave (
        input  sel_i, sel_stb_i, proj_io_out_i, proj_io_oeb_i,
        output io_out, io_oeb, proj_rst_o, proj_active_o, cur_sel_o, busy_o
    );
endinterface

// File: rtl/multi_project_io_arbiter.sv
// Multi-project IO arbiter: hosts NUM_PROJ user designs behind one pad bank.
// A selection request isolates the pads (GUARD), holds the new project in
// reset (RESET), then hands the pads to that project (RUN). A request with
// an out-of-range index deselects every project and returns to IDLE.
module multi_project_io_arbiter #(
    parameter int NUM_PROJ     = 4,
    parameter int IO_W         = 38,
    parameter int GUARD_CYCLES = 4,
    parameter int RESET_CYCLES = 8,
    parameter int SEL_W        = 5
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    multi_project_io_arbiter_if.slave bus
);
    // A phase counter only ever holds (cycles - 1), so log2(max) bits are enough.
    localparam int CNT_MAX = (GUARD_CYCLES > RESET_CYCLES) ? GUARD_CYCLES : RESET_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LIMIT  = SEL_W'(NUM_PROJ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        RESET = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t state, state_n;

    // Strobe/selection capture stage
    logic             stb_p0, stb_p1;
    logic [SEL_W-1:0] sel_p0;
    logic             req;
    logic             req_valid;

    logic [CNT_W-1:0] cnt, cnt_n;
    logic [SEL_W-1:0] cur_sel, cur_sel_n;
    logic             tgt_valid, tgt_valid_n;

    logic [IO_W-1:0]     pad_out_nx;
    logic [IO_W-1:0]     pad_oeb_nx;
    logic [NUM_PROJ-1:0] proj_rst_nx;
    logic [NUM_PROJ-1:0] proj_act_nx;
    logic                busy_nx;

    // The strobe and the index are registered together so the index seen by
    // the FSM is the one present when the strobe rose. Detecting the edge on
    // the registered pair gives the two-cycle request-to-state latency.
    assign req       = stb_p0 & ~stb_p1;
    assign req_valid = (sel_p0 < SEL_LIMIT);

    // Capture the request strobe and selection index.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            stb_p0 <= 1'b0;
            stb_p1 <= 1'b0;
            sel_p0 <= '0;
        end else begin
            stb_p0 <= bus.sel_stb_i;
            stb_p1 <= stb_p0;
            sel_p0 <= bus.sel_i;
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, phase counter and target bookkeeping.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cur_sel_n   = cur_sel;
        tgt_valid_n = tgt_valid;
        unique case (state)
            IDLE: begin
                // A deselect while already idle has nothing to undo.
                if (req && req_valid) begin
                    state_n     = GUARD;
                    cnt_n       = GUARD_LOAD;
                    cur_sel_n   = sel_p0;
                    tgt_valid_n = 1'b1;
                end
            end
            GUARD: begin
                if (req) begin
                    // Restart the whole sequence so no reset pulse is shortened.
                    state_n     = GUARD;
                    cnt_n       = GUARD_LOAD;
                    tgt_valid_n = req_valid;
                    if (req_valid) cur_sel_n = sel_p0;
                end else if (cnt == '0) begin
                    if (tgt_valid) begin
                        state_n = RESET;
                        cnt_n   = RESET_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RESET: begin
                if (req) begin
                    state_n     = GUARD;
                    cnt_n       = GUARD_LOAD;
                    tgt_valid_n = req_valid;
                    if (req_valid) cur_sel_n = sel_p0;
                end else if (cnt == '0) begin
                    state_n = RUN;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RUN: begin
                // Re-selecting the running project is a deliberate reset cycle.
                // A deselect keeps cur_sel so software can read what was last run.
                if (req) begin
                    state_n     = GUARD;
                    cnt_n       = GUARD_LOAD;
                    tgt_valid_n = req_valid;
                    if (req_valid) cur_sel_n = sel_p0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Counter and target registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt       <= '0;
            cur_sel   <= '0;
            tgt_valid <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            cur_sel   <= cur_sel_n;
            tgt_valid <= tgt_valid_n;
        end
    end

    // Output values for the upcoming state. Decoding from the next state makes
    // the pads isolate in the very update that leaves RUN, so the old project
    // never drives a pad once its replacement has been accepted.
    always_comb begin
        pad_out_nx  = '0;
        pad_oeb_nx  = '1;
        proj_rst_nx = '1;
        proj_act_nx = '0;
        busy_nx     = (state_n == GUARD) || (state_n == RESET);
        if (state_n == RUN) begin
            for (int k = 0; k < NUM_PROJ; k++) begin
                if (SEL_W'(k) == cur_sel_n) begin
                    pad_out_nx     = bus.proj_io_out_i[k*IO_W +: IO_W];
                    pad_oeb_nx     = bus.proj_io_oeb_i[k*IO_W +: IO_W];
                    proj_rst_nx[k] = 1'b0;
                    proj_act_nx[k] = 1'b1;
                end
            end
        end
    end

    // Registered pad and status outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bus.io_out        <= '0;
            bus.io_oeb        <= '1;
            bus.proj_rst_o    <= '1;
            bus.proj_active_o <= '0;
            bus.cur_sel_o     <= '0;
            bus.busy_o        <= 1'b0;
        end else begin
            bus.io_out        <= pad_out_nx;
            bus.io_oeb        <= pad_oeb_nx;
            bus.proj_rst_o    <= proj_rst_nx;
            bus.proj_active_o <= proj_act_nx;
            bus.cur_sel_o     <= cur_sel_n;
            bus.busy_o        <= busy_nx;
        end
    end

endmodule

// File: tb/tb_multi_project_io_arbiter.sv
// Bench for multi_project_io_arbiter: directed scenarios followed by a
// random request storm, all compared against a timeline reference model.
module tb_multi_project_io_arbiter;
    localparam int NUM_PROJ = 4;
    localparam int IO_W     = 38;
    localparam int SEL_W    = 5;
    localparam int G        = 4;
    localparam int R        = 8;

    localparam int PH_IDLE  = 0;
    localparam int PH_GUARD = 1;
    localparam int PH_RESET = 2;
    localparam int PH_RUN   = 3;

    logic clk;
    logic rst;

    multi_project_io_arbiter_if #(.NUM_PROJ(NUM_PROJ), .IO_W(IO_W), .SEL_W(SEL_W)) bus();

    multi_project_io_arbiter #(
        .NUM_PROJ(NUM_PROJ), .IO_W(IO_W), .GUARD_CYCLES(G),
        .RESET_CYCLES(R), .SEL_W(SEL_W)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_pass;

    // Reference model: a request accepted at edge t_acc puts the block in
    // GUARD for G edges, then RESET for R edges, then RUN (or IDLE after the
    // guard for a deselect). Everything is a function of edges since t_acc.
    int              m_k;
    bit              m_have_acc;
    int              m_t_acc;
    bit              m_tgt_valid;
    int              m_cur;
    bit              m_stb_prev;
    bit              m_pend;
    int              m_pend_sel;
    logic [IO_W-1:0] m_cap_out;
    logic [IO_W-1:0] m_cap_oeb;

    function automatic int phase_at(int n);
        int e;
        if (!m_have_acc) return PH_IDLE;
        e = n - m_t_acc;
        if (e < G) return PH_GUARD;
        if (!m_tgt_valid) return PH_IDLE;
        if (e < G + R) return PH_RESET;
        return PH_RUN;
    endfunction

    task automatic model_reset();
        m_k         = 0;
        m_have_acc  = 1'b0;
        m_t_acc     = 0;
        m_tgt_valid = 1'b0;
        m_cur       = 0;
        m_stb_prev  = 1'b0;
        m_pend      = 1'b0;
        m_pend_sel  = 0;
        m_cap_out   = '0;
        m_cap_oeb   = '1;
    endtask

    // Called right after a rising edge with the inputs that edge sampled.
    task automatic model_update();
        m_k++;
        if (m_pend) begin
            if (!(phase_at(m_k - 1) == PH_IDLE && m_pend_sel >= NUM_PROJ)) begin
                m_have_acc  = 1'b1;
                m_t_acc     = m_k;
                m_tgt_valid = (m_pend_sel < NUM_PROJ);
                if (m_tgt_valid) m_cur = m_pend_sel;
            end
        end
        m_pend     = bus.sel_stb_i && !m_stb_prev;
        m_pend_sel = int'(bus.sel_i);
        m_stb_prev = bus.sel_stb_i;
        m_cap_out  = bus.proj_io_out_i[m_cur*IO_W +: IO_W];
        m_cap_oeb  = bus.proj_io_oeb_i[m_cur*IO_W +: IO_W];
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, m_k, obs, exp);
    endtask

    task automatic check_model();
        int                  ph;
        logic [IO_W-1:0]     eo, ee;
        logic [NUM_PROJ-1:0] er, ea;
        ph = phase_at(m_k);
        eo = '0;
        ee = '1;
        er = '1;
        ea = '0;
        if (ph == PH_RUN) begin
            eo        = m_cap_out;
            ee        = m_cap_oeb;
            er[m_cur] = 1'b0;
            ea[m_cur] = 1'b1;
        end
        chk("io_out",        64'(bus.io_out),        64'(eo));
        chk("io_oeb",        64'(bus.io_oeb),        64'(ee));
        chk("proj_rst_o",    64'(bus.proj_rst_o),    64'(er));
        chk("proj_active_o", 64'(bus.proj_active_o), 64'(ea));
        chk("cur_sel_o",     64'(bus.cur_sel_o),     64'(m_cur));
        chk("busy_o",        64'(bus.busy_o),
            64'((ph == PH_GUARD) || (ph == PH_RESET)));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".io_out"},        64'(bus.io_out),        64'(0));
        chk({tag, ".io_oeb"},        64'(bus.io_oeb),        64'({IO_W{1'b1}}));
        chk({tag, ".proj_rst_o"},    64'(bus.proj_rst_o),    64'(4'b1111));
        chk({tag, ".proj_active_o"}, 64'(bus.proj_active_o), 64'(0));
        chk({tag, ".cur_sel_o"},     64'(bus.cur_sel_o),     64'(0));
        chk({tag, ".busy_o"},        64'(bus.busy_o),        64'(0));
    endtask

    task automatic randomize_proj();
        logic [63:0] t;
        for (int p = 0; p < NUM_PROJ; p++) begin
            t = {$urandom(), $urandom()};
            bus.proj_io_out_i[p*IO_W +: IO_W] = t[IO_W-1:0];
            t = {$urandom(), $urandom()};
            bus.proj_io_oeb_i[p*IO_W +: IO_W] = t[IO_W-1:0];
        end
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge,
    // then fresh project data is driven for the next edge.
    task automatic step();
        @(posedge clk);
        if (!rst) model_update();
        @(negedge clk);
        if (!rst) check_model();
        randomize_proj();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic strobe(input int s, input int hold);
        bus.sel_i     = SEL_W'(s);
        bus.sel_stb_i = 1'b1;
        run(hold);
        bus.sel_stb_i = 1'b0;
    endtask

    int busy_cnt;

    initial begin
        n_total       = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.sel_i     = '0;
        bus.sel_stb_i = 1'b0;
        randomize_proj();
        model_reset();

        // Reset state
        run(3);
        check_reset_vals("reset");
        rst = 1'b0;
        model_reset();
        run(2);

        // Select project 2: 12 busy cycles then RUN
        strobe(2, 1);
        busy_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.busy_o === 1'b1) busy_cnt++;
        end
        chk("sel2.busy_cycles",   64'(busy_cnt),          64'(12));
        chk("sel2.proj_rst_o",    64'(bus.proj_rst_o),    64'(4'b1011));
        chk("sel2.proj_active_o", 64'(bus.proj_active_o), 64'(4'b0100));
        run(5);

        // Switch to project 1
        strobe(1, 1);
        step();
        chk("sw1.oeb_isolated", 64'(bus.io_oeb), 64'({IO_W{1'b1}}));
        run(13);
        chk("sw1.proj_rst_o", 64'(bus.proj_rst_o), 64'(4'b1101));
        run(4);

        // Deselect with index 31
        strobe(31, 1);
        run(6);
        chk("desel.proj_active_o", 64'(bus.proj_active_o), 64'(0));
        chk("desel.cur_sel_o",     64'(bus.cur_sel_o),     64'(1));
        chk("desel.busy_o",        64'(bus.busy_o),        64'(0));

        // Select 0, then 3 during the RESET phase
        strobe(0, 1);
        run(6);
        chk("resel.in_reset_busy", 64'(bus.busy_o), 64'(1));
        strobe(3, 1);
        run(16);
        chk("resel.proj_rst_o",    64'(bus.proj_rst_o),    64'(4'b0111));
        chk("resel.proj_active_o", 64'(bus.proj_active_o), 64'(4'b1000));

        // Strobe held high for 20 cycles: one request only
        strobe(0, 20);
        run(3);
        chk("hold.cur_sel_o", 64'(bus.cur_sel_o), 64'(0));
        chk("hold.busy_o",    64'(bus.busy_o),    64'(0));

        // Back to IDLE, then an out-of-range index in IDLE is ignored
        strobe(31, 1);
        run(7);
        strobe(7, 1);
        run(4);
        chk("idle7.busy_o", 64'(bus.busy_o), 64'(0));

        // Asynchronous reset in the middle of RESET, between clock edges
        strobe(1, 1);
        run(7);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        model_reset();
        run(2);
        rst = 1'b0;
        model_reset();
        run(5);

        // Random request storm
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 7) == 0) strobe(31, 1);
                else strobe(int'($urandom_range(0, 7)), int'($urandom_range(1, 3)));
            end else begin
                step();
            end
        end
        run(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
